// File: rtl/echo_tof_detector.sv
// Echo time-of-flight detector: rectifies filtered samples after a transmit start,
// qualifies a debounced threshold crossing, and reports tof/peak or a timeout pulse.
module echo_tof_detector #(
  parameter int DW       = 16,
  parameter int CW       = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic signed [DW-1:0] X,
  input  logic [DW-1:0]        threshold,
  input  logic [CW-1:0]        max_count,
  output logic [CW-1:0]        tof,
  output logic [DW-1:0]        peak,
  output logic                 valid,
  output logic                 timeout,
  output logic                 busy
);

  localparam int HW = $clog2(DEBOUNCE + 1);

  typedef enum logic {IDLE, LISTEN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] run_start_q, run_start_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [CW-1:0] tof_q, tof_d;
  logic [DW-1:0] peak_q, peak_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;

  logic [DW-1:0] mag;
  logic [HW-1:0] hits_inc;
  logic          hit, take, last, detect, expire;

  // The most negative code has no positive twin, so it saturates to max positive.
  always_comb begin
    mag = X;
    if (X[DW-1]) begin
      if (X == {1'b1, {(DW-1){1'b0}}}) mag = {1'b0, {(DW-1){1'b1}}};
      else                             mag = $unsigned(-X);
    end
  end

  assign hit      = (mag >= threshold);
  assign hits_inc = hits_q + HW'(1);
  assign take     = (state_q == LISTEN) && en && !start;
  assign last     = (max_count == '0) || (count_q == max_count - CW'(1));
  assign detect   = take && hit && (hits_inc == HW'(DEBOUNCE));
  assign expire   = take && !detect && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LISTEN;
      LISTEN:  if (!start && (detect || expire)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == LISTEN);
    valid_d   = detect;
    timeout_d = expire;
  end

  always_comb begin
    count_d     = count_q;
    run_start_d = run_start_q;
    hits_d      = hits_q;
    tof_d       = tof_q;
    peak_d      = peak_q;
    if (start) begin
      count_d     = '0;
      run_start_d = '0;
      hits_d      = '0;
      peak_d      = '0;
    end else if (take) begin
      count_d = count_q + CW'(1);
      if (mag > peak_q) peak_d = mag;
      if (hit) begin
        if (hits_q == '0) run_start_d = count_q;
        hits_d = hits_inc;
      end else begin
        hits_d = '0;
      end
      // A run that starts on this very sample has no stored run_start yet.
      if (detect)      tof_d = (hits_q == '0) ? count_q : run_start_q;
      else if (expire) tof_d = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      run_start_q <= '0;
      hits_q      <= '0;
      tof_q       <= '0;
      peak_q      <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      run_start_q <= run_start_d;
      hits_q      <= hits_d;
      tof_q       <= tof_d;
      peak_q      <= peak_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign tof     = tof_q;
  assign peak    = peak_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_echo_tof_detector.sv
// Scoreboarded bench for echo_tof_detector: expected reports are queued when the
// deciding sample is driven and checked by a monitor when valid/timeout pulses.
module tb_echo_tof_detector;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               start;
  logic signed [15:0] X;
  logic [15:0]        threshold;
  logic [15:0]        max_count;
  logic [15:0]        tof;
  logic [15:0]        peak;
  logic               valid;
  logic               timeout;
  logic               busy;

  typedef struct {
    logic        is_to;
    logic [15:0] tof;
    logic [15:0] peak;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  echo_tof_detector #(.DW(16), .CW(16), .DEBOUNCE(3)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .X(X),
    .threshold(threshold), .max_count(max_count),
    .tof(tof), .peak(peak), .valid(valid), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (valid || timeout)) begin
      exp_t e;
      n_tests++;
      if (valid && timeout) begin
        n_fail++;
        $display("FAIL pulse_excl: valid=%0b timeout=%0b, required not both", valid, timeout);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%0b timeout=%0b tof=%0d, required no pulse",
                 valid, timeout, tof);
      end else begin
        e = sb.pop_front();
        if (timeout !== e.is_to || valid !== !e.is_to || tof !== e.tof ||
            peak !== e.peak || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL report: got to=%0b v=%0b tof=%0d peak=%0d busy=%0b, required to=%0b tof=%0d peak=%0d busy=0",
                   timeout, valid, tof, peak, busy, e.is_to, e.tof, e.peak);
        end
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic smp(input logic signed [15:0] x);
    en = 1'b1;
    X  = x;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic expect_rep(input logic is_to, input logic [15:0] t, input logic [15:0] p);
    exp_t e;
    e.is_to = is_to;
    e.tof   = t;
    e.peak  = p;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d reports outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; start = 1'b0; X = '0;
    threshold = 16'd1000; max_count = 16'd100;
    #12;
    n_tests++;
    if ({tof, peak, valid, timeout, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: tof=%0d peak=%0d v=%0b to=%0b busy=%0b, required all 0",
               tof, peak, valid, timeout, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    do_start();
    smp(16'sd2000);
    n_tests++;
    if (busy !== 1'b1 || peak !== 16'd2000) begin
      n_fail++;
      $display("FAIL reset_busy: busy=%0b peak=%0d, required busy=1 peak=2000", busy, peak);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({tof, peak, valid, timeout, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: tof=%0d peak=%0d v=%0b to=%0b busy=%0b, required all 0",
               tof, peak, valid, timeout, busy);
    end
    #2 rst = 1'b0;
    repeat (5) smp(16'sd3000);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    threshold = 16'd1000; max_count = 16'd100;
    do_start();
    repeat (10) smp(16'sd100);
    smp(16'sd1200);
    smp(-16'sd1300);
    expect_rep(1'b0, 16'd10, 16'd1300);
    smp(16'sd1100);
    wait_drain("basic");
  endtask

  task automatic test_glitch();
    logic signed [15:0] s [8];
    s = '{16'sd50, 16'sd1200, 16'sd80, 16'sd90, 16'sd95, 16'sd1500, 16'sd1500, 16'sd1500};
    do_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_rep(1'b0, 16'd5, 16'd1500);
      smp(s[i]);
    end
    wait_drain("glitch");
  endtask

  task automatic test_saturation();
    threshold = 16'd32767; max_count = 16'd100;
    do_start();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) expect_rep(1'b0, 16'd0, 16'd32767);
      smp(-16'sd32768);
      if (i < 2) begin
        repeat (4) @(posedge clk);
        #1;
      end
    end
    wait_drain("sat");
  endtask

  task automatic test_timeout();
    threshold = 16'd1000; max_count = 16'd20;
    do_start();
    repeat (19) smp(16'sd10);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: busy=%0b at k=18, required 1", busy);
    end
    expect_rep(1'b1, 16'hFFFF, 16'd10);
    smp(-16'sd10);
    wait_drain("timeout");
    max_count = 16'd0;
    do_start();
    expect_rep(1'b1, 16'hFFFF, 16'd7);
    smp(-16'sd7);
    wait_drain("timeout_zero");
  endtask

  task automatic test_restart();
    threshold = 16'd1000; max_count = 16'd100;
    do_start();
    repeat (5) smp(16'sd100);
    smp(16'sd1200);
    smp(16'sd1200);
    do_start();
    repeat (2) smp(16'sd1100);
    expect_rep(1'b0, 16'd0, 16'd1100);
    smp(16'sd1100);
    wait_drain("restart");
  endtask

  task automatic test_start_with_en();
    threshold = 16'd1000; max_count = 16'd100;
    do_start();
    smp(16'sd100);
    start = 1'b1; en = 1'b1; X = 16'sd5000;
    @(posedge clk); #1;
    start = 1'b0; en = 1'b0;
    repeat (2) smp(16'sd1100);
    expect_rep(1'b0, 16'd0, 16'd1100);
    smp(16'sd1100);
    wait_drain("start_en");
  endtask

  task automatic test_start_on_decide();
    threshold = 16'd1000; max_count = 16'd100;
    do_start();
    repeat (2) smp(16'sd1100);
    start = 1'b1; en = 1'b1; X = 16'sd1100;
    @(posedge clk); #1;
    start = 1'b0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1 || peak !== 16'd0) begin
      n_fail++;
      $display("FAIL start_decide: busy=%0b peak=%0d, required busy=1 peak=0", busy, peak);
    end
    smp(16'sd1400);
    smp(16'sd1100);
    expect_rep(1'b0, 16'd0, 16'd1400);
    smp(16'sd1100);
    wait_drain("start_decide");
  endtask

  task automatic test_hit_on_last();
    threshold = 16'd1000; max_count = 16'd5;
    do_start();
    repeat (2) smp(16'sd100);
    repeat (2) smp(16'sd1100);
    expect_rep(1'b0, 16'd2, 16'd1100);
    smp(16'sd1100);
    wait_drain("hit_last");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_saturation();
    test_timeout();
    test_restart();
    test_start_with_en();
    test_start_on_decide();
    test_hit_on_last();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
